// File: rtl/result_frame_accumulator_if.sv
// Stream bundle for result_frame_accumulator: sample input, frame length and frame-total output.
// The accumulator takes the slave modport; the producer/consumer side takes master.
interface result_frame_accumulator_if #(
  parameter int unsigned IN_W  = 36,
  parameter int unsigned OUT_W = 44,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic [CNT_W-1:0] frame_len;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  modport master (
    output in_valid, in_data, frame_len, out_ready,
    input  in_ready, out_valid, out_data, out_count, overflow
  );

  modport slave (
    input  in_valid, in_data, frame_len, out_ready,
    output in_ready, out_valid, out_data, out_count, overflow
  );
endinterface

// File: rtl/result_frame_accumulator.sv
// Sums a frame of unsigned upstream results and presents the total on a valid/ready port.
// Define RFA_SATURATE_EN to clamp the sum to all ones on overflow instead of wrapping.
module result_frame_accumulator #(
  parameter int unsigned IN_W  = 36,
  parameter int unsigned OUT_W = 44,
  parameter int unsigned CNT_W = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  result_frame_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e           state_q;
  logic [OUT_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [OUT_W:0]   sum;

  always_comb begin
    accept  = bus.in_valid & in_ready_q;
    len_eff = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
    cnt_inc = cnt_q + CNT_W'(1);
    // One extra bit so the carry out of the accumulator is visible.
    sum     = {1'b0, acc_q} + (OUT_W + 1)'(bus.in_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= OUT_W'(bus.in_data);
            cnt_q <= CNT_W'(1);
            len_q <= len_eff;
            ovf_q <= 1'b0;
            if (len_eff == CNT_W'(1)) begin
              state_q     <= StOut;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StAcc;
            end
          end
        end
        StAcc: begin
          if (accept) begin
`ifdef RFA_SATURATE_EN
            // Once clamped, any further nonzero add carries again, so the clamp holds.
            acc_q <= sum[OUT_W] ? '1 : sum[OUT_W-1:0];
`else
            acc_q <= sum[OUT_W-1:0];
`endif
            ovf_q <= ovf_q | sum[OUT_W];
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q     <= StOut;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.overflow  = ovf_q;

endmodule
